// File: rtl/ultraembedded_tcm_axi_initiator_pkg.sv
// ---------------------------------------------------------------------------
// ultraembedded_tcm_axi_initiator_pkg
//   Shared definitions for the TCM-to-AXI4 single-outstanding initiator:
//   - state_e        : FSM state encoding
//   - AXI_RESP_*     : AXI4 BRESP/RRESP codes
//   - resp_is_err()  : maps an AXI response code onto the core error flag
// ---------------------------------------------------------------------------
package ultraembedded_tcm_axi_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_WAIT_B = 3'd2,
    ST_AR     = 3'd3,
    ST_WAIT_R = 3'd4
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Both error codes have bit 1 set; OKAY/EXOKAY are successes.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/ultraembedded_tcm_axi_initiator.sv
// ---------------------------------------------------------------------------
// ultraembedded_tcm_axi_initiator
//   Converts a simple core request/response port into single-beat AXI4
//   transactions, one outstanding at a time.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o      core request handshake (ready only in IDLE)
//   req_wr_i, req_addr_i,        request direction, byte address,
//   req_wdata_i, req_strb_i      write data and byte enables
//   resp_valid_o                 one-cycle completion pulse
//   resp_rdata_o, resp_err_o     read data (0 for writes), error flag
//   axi_aw*/axi_w*/axi_b*        AXI4 write address/data/response channels
//   axi_ar*/axi_r*               AXI4 read address/data channels
// ---------------------------------------------------------------------------
module ultraembedded_tcm_axi_initiator
  import ultraembedded_tcm_axi_initiator_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req_valid_i,
  input  logic        req_wr_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_strb_i,
  output logic        req_ready_o,

  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,

  output logic        axi_awvalid_o,
  output logic [31:0] axi_awaddr_o,
  input  logic        axi_awready_i,

  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  input  logic        axi_wready_i,

  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  output logic        axi_bready_o,

  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  input  logic        axi_arready_i,

  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  output logic        axi_rready_o
);

  state_e      state_reg, state_next;

  logic        awvalid_reg, awvalid_next;
  logic        wvalid_reg, wvalid_next;
  logic        arvalid_reg, arvalid_next;

  logic        resp_valid_reg, resp_valid_next;
  logic [31:0] resp_rdata_reg, resp_rdata_next;
  logic        resp_err_reg, resp_err_next;

  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  strb_reg;

  logic        req_accept;

  assign req_accept = (state_reg == ST_IDLE) && req_valid_i;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    awvalid_next    = awvalid_reg;
    wvalid_next     = wvalid_reg;
    arvalid_next    = arvalid_reg;
    resp_valid_next = 1'b0;
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_wr_i) begin
            state_next   = ST_WR;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            state_next   = ST_AR;
            arvalid_next = 1'b1;
          end
        end
      end

      ST_WR: begin
        // AW and W complete independently; leave once both are done,
        // which may happen in the same cycle.
        if (awvalid_reg && axi_awready_i) awvalid_next = 1'b0;
        if (wvalid_reg && axi_wready_i)   wvalid_next  = 1'b0;
        if (!awvalid_next && !wvalid_next) state_next = ST_WAIT_B;
      end

      ST_WAIT_B: begin
        if (axi_bvalid_i) begin
          state_next      = ST_IDLE;
          resp_valid_next = 1'b1;
          resp_rdata_next = 32'h0;
          resp_err_next   = resp_is_err(axi_bresp_i);
        end
      end

      ST_AR: begin
        if (axi_arready_i) begin
          arvalid_next = 1'b0;
          state_next   = ST_WAIT_R;
        end
      end

      ST_WAIT_R: begin
        if (axi_rvalid_i) begin
          state_next      = ST_IDLE;
          resp_valid_next = 1'b1;
          resp_rdata_next = axi_rdata_i;
          resp_err_next   = resp_is_err(axi_rresp_i);
        end
      end

      default: begin
        state_next   = ST_IDLE;
        awvalid_next = 1'b0;
        wvalid_next  = 1'b0;
        arvalid_next = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output and payload registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      awvalid_reg    <= 1'b0;
      wvalid_reg     <= 1'b0;
      arvalid_reg    <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= 1'b0;
      addr_reg       <= 32'h0;
      wdata_reg      <= 32'h0;
      strb_reg       <= 4'h0;
    end else begin
      awvalid_reg    <= awvalid_next;
      wvalid_reg     <= wvalid_next;
      arvalid_reg    <= arvalid_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
      if (req_accept) begin
        // AXI side is word-addressed; byte lanes are selected by strobes.
        addr_reg  <= req_addr_i & 32'hFFFF_FFFC;
        wdata_reg <= req_wdata_i;
        strb_reg  <= req_strb_i;
      end
    end
  end

  assign req_ready_o   = (state_reg == ST_IDLE);

  assign resp_valid_o  = resp_valid_reg;
  assign resp_rdata_o  = resp_rdata_reg;
  assign resp_err_o    = resp_err_reg;

  assign axi_awvalid_o = awvalid_reg;
  assign axi_awaddr_o  = addr_reg;
  assign axi_wvalid_o  = wvalid_reg;
  assign axi_wdata_o   = wdata_reg;
  assign axi_wstrb_o   = strb_reg;
  assign axi_bready_o  = (state_reg == ST_WAIT_B);

  assign axi_arvalid_o = arvalid_reg;
  assign axi_araddr_o  = addr_reg;
  assign axi_rready_o  = (state_reg == ST_WAIT_R);

endmodule
